// File: rtl/plic_pkg.sv
// plic_pkg: shared PLIC types, ID width helper and post-claim blanking lengths.
package plic_pkg;
  localparam int PW_MAX = 8;
  localparam int IW_MAX = 16;
  localparam logic [1:0] BLANK_PIPE = 2'd3;
  localparam logic [1:0] BLANK_COMB = 2'd2;
  typedef struct packed {
    logic [PW_MAX-1:0] prio;
    logic [IW_MAX-1:0] id;
  } prio_id_t;
  function automatic int id_width(input int sources);
    return $clog2(sources + 1);
  endfunction
endpackage

// File: rtl/plic_priority_index.sv
// plic_priority_index: combinational max-priority tree over {prio, id} pairs; ties go to the lower ID.
module plic_priority_index import plic_pkg::*; #(
  parameter int SOURCES = 16,
  parameter int PRIORITY_BITS = 3
) (
  input  logic [SOURCES-1:0][PRIORITY_BITS-1:0] prio_i,
  output prio_id_t                              best_o
);
  localparam int LEAVES = 1 << $clog2(SOURCES);
  prio_id_t node [2*LEAVES-1];
  for (genvar l = 0; l < LEAVES; l++) begin : g_leaf
    if (l < SOURCES) begin : g_src
      assign node[LEAVES-1+l] = '{prio: PW_MAX'(prio_i[l]), id: IW_MAX'(l + 1)};
    end else begin : g_pad
      assign node[LEAVES-1+l] = '0;
    end
  end
  // Leaves are in ID order, so preferring the left child on ties keeps the lower ID.
  for (genvar n = 0; n < LEAVES - 1; n++) begin : g_node
    assign node[n] = node[2*n+1].prio >= node[2*n+2].prio ? node[2*n+1] : node[2*n+2];
  end
  assign best_o = node[0];
endmodule

// File: rtl/plic_target.sv
// plic_target: per-target PLIC arbitration, claim/complete strobes and post-claim blanking.
// Defining PLIC_TARGET_PIPE_EN adds the S2 register (3-cycle latency, 3 blanking cycles).
module plic_target import plic_pkg::*; #(
  parameter  int SOURCES       = 16,
  parameter  int PRIORITIES    = 8,
  localparam int PRIORITY_BITS = $clog2(PRIORITIES),
  localparam int IW            = id_width(SOURCES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [SOURCES-1:0]                    ip_i,
  input  logic [SOURCES-1:0]                    ie_i,
  input  logic [SOURCES-1:0][PRIORITY_BITS-1:0] priority_i,
  input  logic [PRIORITY_BITS-1:0]              threshold_i,
  output logic                                  ireq_o,
  output logic [IW-1:0]                         id_o,
  input  logic                                  claim_req_i,
  output logic [IW-1:0]                         claim_id_o,
  output logic [SOURCES-1:0]                    claim_o,
  input  logic                                  complete_req_i,
  input  logic [IW-1:0]                         complete_id_i,
  output logic [SOURCES-1:0]                    complete_o
);
  logic [SOURCES-1:0][PRIORITY_BITS-1:0] mprio_q, mprio_d;
  prio_id_t tree, best;
  logic [1:0] blank_q, blank_d;
  logic ireq_q, ireq_d, accept, cmp_ok;
  logic [IW-1:0] id_q, id_d, claim_id_q, claim_id_d;
  logic [SOURCES-1:0] claim_q, claim_d, complete_q, complete_d;

  plic_priority_index #(.SOURCES(SOURCES), .PRIORITY_BITS(PRIORITY_BITS)) u_tree (
    .prio_i(mprio_q),
    .best_o(tree)
  );

`ifdef PLIC_TARGET_PIPE_EN
  localparam logic [1:0] BLANK = BLANK_PIPE;
  prio_id_t best_q;
  always_ff @(posedge clk)
    best_q <= rst ? '0 : tree;
  assign best = best_q;
`else
  localparam logic [1:0] BLANK = BLANK_COMB;
  assign best = tree;
`endif

  // The claimed source is masked while its strobe is out, since the gateway's ip only drops a cycle later.
  always_comb begin
    for (int i = 0; i < SOURCES; i++)
      mprio_d[i] = ip_i[i] & ie_i[i] & ~claim_q[i] ? priority_i[i] : '0;
    accept     = claim_req_i && id_q != '0;
    ireq_d     = !accept && blank_q <= 2'd1 && best.prio > PW_MAX'(threshold_i) && best.id != '0;
    id_d       = ireq_d ? best.id[IW-1:0] : '0;
    claim_id_d = claim_req_i ? id_q : claim_id_q;
    claim_d    = accept ? SOURCES'(1) << (id_q - 1'b1) : '0;
    blank_d    = accept ? BLANK : blank_q - (blank_q != 2'd0 ? 2'd1 : 2'd0);
    cmp_ok     = complete_req_i && complete_id_i != '0 && complete_id_i <= IW'(SOURCES);
    complete_d = cmp_ok ? SOURCES'(1) << (complete_id_i - 1'b1) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mprio_q    <= '0;
      ireq_q     <= 1'b0;
      id_q       <= '0;
      claim_id_q <= '0;
      claim_q    <= '0;
      complete_q <= '0;
      blank_q    <= '0;
    end else begin
      mprio_q    <= mprio_d;
      ireq_q     <= ireq_d;
      id_q       <= id_d;
      claim_id_q <= claim_id_d;
      claim_q    <= claim_d;
      complete_q <= complete_d;
      blank_q    <= blank_d;
    end
  end

  assign ireq_o     = ireq_q;
  assign id_o       = id_q;
  assign claim_id_o = claim_id_q;
  assign claim_o    = claim_q;
  assign complete_o = complete_q;
endmodule

// File: doc/plic_target.md
# plic_target

Per-target arbitration stage of the PLIC, directly downstream of the per-source gateways. It collects every gateway's `ip` bit, masks it with the target's enables, and selects the highest-priority pending source above the target threshold. It presents the interrupt request and ID to the target, and turns the target's claim/complete register accesses into one-cycle `claim`/`complete` strobes back to the gateways.

## Interface
Parameters:
- `SOURCES`, 16: number of interrupt sources; source IDs are 1..SOURCES, and ID 0 means "none".
- `PRIORITIES`, 8: number of priority levels.
  - `PRIORITY_BITS` = $clog2(PRIORITIES).
  - Priority 0 never interrupts.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `ip`, input, SOURCES: pending bits from the gateways; bit i-1 is source i.
- `ie`, input, SOURCES: per-source enable for this target.
- `priority`, input, SOURCES x PRIORITY_BITS: per-source priority.
- `threshold`, input, PRIORITY_BITS: target priority threshold.
- `ireq`, output, 1: interrupt request to the target.
- `id`, output, $clog2(SOURCES+1): highest-priority eligible source ID, or 0.
- `claim_req`, input, 1: single-cycle strobe, the target reads its claim register.
- `claim_id`, output, $clog2(SOURCES+1): ID returned by the last claim.
- `claim`, output, SOURCES: one-hot, one-cycle claim strobe to the gateways.
- `complete_req`, input, 1: single-cycle strobe, the target writes its complete register.
- `complete_id`, input, $clog2(SOURCES+1): ID being completed.
- `complete`, output, SOURCES: one-hot, one-cycle complete strobe to the gateways.

## Operation
Eligibility:
- Source i is eligible when `ip[i-1] & ie[i-1]` is set and `priority[i] > threshold` (strict).
- Priority 0 is therefore never eligible, and `threshold` = PRIORITIES-1 masks every source.

Selection:
- The winner is the eligible source with the highest priority.
- Ties go to the lowest ID.
- No eligible source: `id`=0 and `ireq`=0.

Pipeline:
- S1 registers the masked priority per source: the priority if `ip & ie`, else 0.
- S2 registers the tree result {best_prio, best_id}.
- Output register: `ireq` = (best_prio > threshold); `id` = best_id if `ireq`, else 0.

Claim:
- On `claim_req`, the current registered `id` is captured into `claim_id` on the next edge.
- If that `id` ≠ 0, `claim[id-1]` pulses for exactly one cycle, starting the cycle after `claim_req`.
- If `id` = 0, `claim_id` becomes 0 and no strobe is issued.

Blanking:
- Starting with the cycle that follows an accepted claim, `ireq` and `id` are forced to 0 for BLANK cycles.
- This hides the stale winner while the gateway's `ip` falls and the pipeline refills.
- A `claim_req` during blanking returns 0 and issues no strobe.
- The blanking counter is 2 bits, loaded with BLANK and decremented to 0.

Complete:
- On `complete_req` with 1 ≤ `complete_id` ≤ SOURCES, `complete[complete_id-1]` pulses for one cycle on the next cycle.
- `complete_id` = 0 or > SOURCES is ignored; no strobe is issued.

Simultaneous events:
- `claim_req` and `complete_req` in the same cycle are both serviced independently.
- Claim and complete of the same ID in the same cycle produce both strobes.
- The gateway ignores the complete because it is not yet in the claimed state; that is the software's error.

Reset:
- All pipeline registers, `ireq`, `id`, `claim_id`, `claim`, `complete` and the blanking counter are cleared to 0.
- A reset mid-blank or mid-strobe aborts it; the strobe does not reappear after reset.

## Timing
Latency and blanking depend on `PLIC_TARGET_PIPE_EN`:
- Defined: `ip`/`ie`/`priority` change to `ireq`/`id` takes 3 cycles (S1, S2, out); BLANK = 3.
- Undefined: 2 cycles; BLANK = 2.

Claim cycle accounting, with `claim_req` in cycle t:
- `claim` and `claim_id` are valid in t+1.
- The gateway `ip` is low from t+2.
- The first non-blanked `ireq`/`id` appears at t+1+BLANK.

Other timing rules:
- `threshold` changes take effect at the output register, one cycle later.
- `claim`/`complete` are high for exactly one cycle per accepted request.
- Back-to-back `claim_req` is legal; the second returns 0 because of blanking.

## Configuration
`PLIC_TARGET_PIPE_EN`:
- Defined: the S2 register is present, which suits large SOURCES and high clock rates.
- Undefined: the tree output feeds the output register combinationally from S1, latency drops by one, and BLANK = 2.
- Functional results are identical apart from latency.

## Structure
- Shared package `plic_pkg` holds:
  - the ID width function: clog2(SOURCES+1);
  - the priority/ID pair struct `{prio, id}`;
  - the BLANK constants for each configuration.
- Sub-module `plic_priority_index`: a combinational binary comparison tree over SOURCES {prio, id} pairs.
  - It returns the max-priority pair, with the lower ID winning ties.
  - It is parameterised on SOURCES and PRIORITY_BITS.
- `plic_target` holds the S1/S2/output registers, the claim/complete decode and the blanking counter.

## Test plan
1. Reset with `ip`=0 → all outputs 0. Then `ip`=0x0010, `ie`=0xFFFF, prio[5]=3, `threshold`=0 → `ireq`=1, `id`=5 after 3 cycles (pipe defined).
2. Sources 3 and 9 pending, both prio 4 → `id`=3. Raise prio[9] to 6 → `id`=9. Set `threshold`=6 → `ireq`=0, `id`=0.
3. `id`=5, pulse `claim_req` → `claim`=0x0010 for exactly 1 cycle and `claim_id`=5. `ireq` stays 0 for 3 cycles. Drop `ip[4]` one cycle after the strobe → `ireq` stays 0 afterwards.
4. `claim_req` with no eligible source, and `claim_req` again 1 cycle after an accepted claim → both return `claim_id`=0 and `claim`=0.
5. `complete_req` with IDs 7, 0 and 17 (SOURCES=16) → `complete`=0x0040 for ID 7; no strobe for 0 or 17. Same-cycle claim of 5 and complete of 7 → both strobes in the same cycle.
6. Assert `rst` in the cycle after `claim_req` → `claim`, `claim_id`, `ireq` and `id` are all 0 the next cycle, and blanking is cleared.
